// File: rtl/picorv32_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : picorv32_mem_responder
//  Description : Single-port RAM slave for the PicoRV32 native memory bus
//                (mem_valid/mem_ready). Serves fetches, loads and byte-strobed
//                stores after a fixed number of wait states, reports program
//                completion through a tohost mailbox, flags out-of-range or
//                aborted accesses and counts completed fetches and writes.
//  Revision    : 1.0  initial release
// ============================================================================
module picorv32_mem_responder #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        done,
    output logic        pass,
    output logic        err,
    output logic [31:0] fetch_count,
    output logic [31:0] write_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int unsigned IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] c_SPAN  = 32'(MEM_WORDS * 4);
    localparam logic [3:0]  c_WAIT  = 4'(WAIT_STATES);

    localparam logic [1:0]  c_IDLE  = 2'd0;
    localparam logic [1:0]  c_WAITS = 2'd1;
    localparam logic [1:0]  c_RESP  = 2'd2;

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [31:0]      ram_q [0:MEM_WORDS-1];

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [3:0]       cnt_q;
    logic [3:0]       cnt_d;

    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic             instr_q;

    logic [31:0]      rdata_q;
    logic             done_q;
    logic             pass_q;
    logic             err_q;
    logic [31:0]      fetch_cnt_q;
    logic [31:0]      write_cnt_q;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic             w_capture;
    logic             w_abort;
    logic             w_access;
    logic             w_resp;
    logic [31:0]      w_acc_addr;
    logic [31:0]      w_acc_wdata;
    logic [3:0]       w_acc_wstrb;
    logic [31:0]      w_acc_off;
    logic             w_acc_in_range;
    logic [IDX_W-1:0] w_idx;
    logic             w_ram_we;
    logic             w_rd_load;
    logic [31:0]      w_merge;
    logic [31:0]      w_resp_off;
    logic             w_resp_in_range;
    logic             w_resp_write;
    logic             w_tohost;

    // State register and wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: capture, count down wait states, respond for one cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_IDLE: begin
                if (mem_valid) begin
                    cnt_d   = c_WAIT;
                    state_d = (c_WAIT == 4'd0) ? c_RESP : c_WAITS;
                end
            end
            c_WAITS: begin
                if (!mem_valid) begin
                    // Initiator withdrew the request: abandon without access
                    state_d = c_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = c_RESP;
                    end
                end
            end
            c_RESP:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // Output/control decode derived from the FSM
    always_comb begin
        w_capture = (state_q == c_IDLE) && mem_valid;
        w_abort   = (state_q == c_WAITS) && !mem_valid;
        w_resp    = (state_q == c_RESP);
        // The access edge is the edge that enters RESP; with no wait states
        // that is the capture edge itself, so the live bus is used there.
        w_access  = (state_d == c_RESP) && (state_q != c_RESP) && !reset;
        mem_ready = w_resp;
    end

    // Address decode for the access edge
    always_comb begin
        if (state_q == c_IDLE) begin
            w_acc_addr  = mem_addr;
            w_acc_wdata = mem_wdata;
            w_acc_wstrb = mem_wstrb;
        end else begin
            w_acc_addr  = addr_q;
            w_acc_wdata = wdata_q;
            w_acc_wstrb = wstrb_q;
        end
        // Unsigned 32-bit offset: addresses below the base wrap high and fail
        // the range compare just like addresses past the top.
        w_acc_off      = w_acc_addr - ADDR_BASE;
        w_acc_in_range = (w_acc_off < c_SPAN);
        w_idx          = w_acc_off[IDX_W+1:2];
        w_ram_we       = w_access && w_acc_in_range && (w_acc_wstrb != 4'h0);
        w_rd_load      = w_access && (w_acc_wstrb == 4'h0);
    end

    // Byte-lane merge of store data over the current RAM word
    always_comb begin
        w_merge = ram_q[w_idx];
        for (int b = 0; b < 4; b++) begin
            if (w_acc_wstrb[b]) begin
                w_merge[8*b +: 8] = w_acc_wdata[8*b +: 8];
            end
        end
    end

    // Retirement decode for the RESP cycle, from the captured request
    always_comb begin
        w_resp_off      = addr_q - ADDR_BASE;
        w_resp_in_range = (w_resp_off < c_SPAN);
        w_resp_write    = (wstrb_q != 4'h0);
        w_tohost        = ({addr_q[31:2], 2'b00} == TOHOST_ADDR);
    end

    // RAM array write port (contents survive reset)
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            ram_q[w_idx] <= w_merge;
        end
    end

    // Request capture; later bus changes are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            instr_q <= 1'b0;
        end else if (w_capture) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            instr_q <= mem_instr;
        end
    end

    // Read data register: loaded on read access edges, held across writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'h0;
        end else if (w_rd_load) begin
            rdata_q <= w_acc_in_range ? ram_q[w_idx] : 32'h0;
        end
    end

    // Sticky status flags and transaction counters, retired in RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= 1'b0;
            fetch_cnt_q <= 32'h0;
            write_cnt_q <= 32'h0;
        end else begin
            if (w_abort) begin
                err_q <= 1'b1;
            end
            if (w_resp) begin
                if (!w_resp_in_range) begin
                    err_q <= 1'b1;
                end
                if (instr_q && !w_resp_write) begin
                    fetch_cnt_q <= fetch_cnt_q + 32'd1;
                end
                if (w_resp_write) begin
                    write_cnt_q <= write_cnt_q + 32'd1;
                    // Only the first mailbox write decides the verdict
                    if (w_tohost && !done_q) begin
                        done_q <= 1'b1;
                        pass_q <= (wdata_q == 32'h1) && (wstrb_q == 4'hF);
                    end
                end
            end
        end
    end

    assign mem_rdata   = rdata_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err         = err_q;
    assign fetch_count = fetch_cnt_q;
    assign write_count = write_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_picorv32_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_picorv32_mem_responder
//  Description : Self-checking bench for picorv32_mem_responder. Two
//                instances (0 and 3 wait states) share the request bus; a
//                scoreboard queue holds expected latency and read data.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_picorv32_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  ready;
    logic [1:0]  done;
    logic [1:0]  pass;
    logic [1:0]  err;
    logic [31:0] rdata [2];
    logic [31:0] fcnt  [2];
    logic [31:0] wcnt  [2];

    typedef struct {
        bit          check_data;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mdl [int];
    int          exp_f [2];
    int          exp_w [2];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    picorv32_mem_responder #(
        .MEM_WORDS(1024), .ADDR_BASE(32'h0), .WAIT_STATES(0),
        .TOHOST_ADDR(32'h1000), .INIT_FILE("")
    ) u_ws0 (
        .clk(clk), .reset(reset), .mem_valid(valid[0]), .mem_instr(instr),
        .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb),
        .mem_ready(ready[0]), .mem_rdata(rdata[0]), .done(done[0]),
        .pass(pass[0]), .err(err[0]), .fetch_count(fcnt[0]), .write_count(wcnt[0])
    );

    picorv32_mem_responder #(
        .MEM_WORDS(1024), .ADDR_BASE(32'h0), .WAIT_STATES(3),
        .TOHOST_ADDR(32'h1000), .INIT_FILE("")
    ) u_ws3 (
        .clk(clk), .reset(reset), .mem_valid(valid[1]), .mem_instr(instr),
        .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb),
        .mem_ready(ready[1]), .mem_rdata(rdata[1]), .done(done[1]),
        .pass(pass[1]), .err(err[1]), .fetch_count(fcnt[1]), .write_count(wcnt[1])
    );

    function automatic int key(input int sel, input logic [31:0] a);
        return sel * 4096 + int'(a[11:2]);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_f[0] = 0; exp_f[1] = 0;
        exp_w[0] = 0; exp_w[1] = 0;
    endtask

    // One complete bus transaction on instance sel; scrambles the bus after capture
    task automatic access(input int sel, input logic is_instr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        int   n;
        bit   got;
        e.check_data = 1'b0;
        e.data       = 32'h0;
        e.lat        = (sel == 0) ? 1 : 4;
        if (s == 4'h0) begin
            if (a >= 32'h1000) begin
                e.check_data = 1'b1;
            end else if (mdl.exists(key(sel, a))) begin
                e.check_data = 1'b1;
                e.data       = mdl[key(sel, a)];
            end
        end
        sb.push_back(e);
        instr = is_instr; addr = a; wdata = d; wstrb = s;
        valid[sel] = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                instr = ~is_instr; addr = ~a; wdata = ~d; wstrb = ~s;
            end
            if (ready[sel] === 1'b1) got = 1'b1;
        end
        valid[sel] = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL timeout[%0d] addr=%h: no mem_ready within %0d cycles", sel, a, n);
        end else begin
            checks++;
            if (n !== e.lat) begin
                errors++;
                $display("FAIL latency[%0d] addr=%h: got %0d cycles, expected %0d", sel, a, n, e.lat);
            end
            if (e.check_data) begin
                checks++;
                if (rdata[sel] !== e.data) begin
                    errors++;
                    $display("FAIL rdata[%0d] addr=%h: got %h, expected %h", sel, a, rdata[sel], e.data);
                end
            end
            if (s != 4'h0) exp_w[sel]++;
            else if (is_instr) exp_f[sel]++;
            if (s != 4'h0 && a < 32'h1000) begin
                if (s == 4'hF) begin
                    mdl[key(sel, a)] = d;
                end else if (mdl.exists(key(sel, a))) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) mdl[key(sel, a)][8*b +: 8] = d[8*b +: 8];
                end
            end
            @(posedge clk);
            #1;
            checks++;
            if (ready[sel] !== 1'b0) begin
                errors++;
                $display("FAIL ready_pulse[%0d]: mem_ready=%b one cycle later, expected 0", sel, ready[sel]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int sel = 0; sel < 2; sel++) begin
            checks += 7;
            if (ready[sel] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d]: got %b expected 0", sel, ready[sel]); end
            if (rdata[sel] !== 32'h0) begin errors++; $display("FAIL reset_rdata[%0d]: got %h expected 0", sel, rdata[sel]); end
            if (done[sel] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b expected 0", sel, done[sel]); end
            if (pass[sel] !== 1'b0) begin errors++; $display("FAIL reset_pass[%0d]: got %b expected 0", sel, pass[sel]); end
            if (err[sel] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b expected 0", sel, err[sel]); end
            if (fcnt[sel] !== 32'h0) begin errors++; $display("FAIL reset_fcnt[%0d]: got %0d expected 0", sel, fcnt[sel]); end
            if (wcnt[sel] !== 32'h0) begin errors++; $display("FAIL reset_wcnt[%0d]: got %0d expected 0", sel, wcnt[sel]); end
        end
    endtask

    task automatic test_fetch();
        access(0, 1'b0, 32'h0, 32'h000012b7, 4'hF);
        access(0, 1'b1, 32'h0, 32'h0, 4'h0);
        checks++;
        if (rdata[0] !== 32'h000012b7) begin errors++; $display("FAIL fetch_data: got %h expected 000012b7", rdata[0]); end
        access(0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks += 2;
        if (fcnt[0] !== 32'(exp_f[0])) begin errors++; $display("FAIL fetch_count: got %0d expected %0d", fcnt[0], exp_f[0]); end
        if (wcnt[0] !== 32'(exp_w[0])) begin errors++; $display("FAIL fetch_wcount: got %0d expected %0d", wcnt[0], exp_w[0]); end
    endtask

    task automatic test_byte_strobe();
        access(1, 1'b0, 32'h40, 32'h11223344, 4'hF);
        access(1, 1'b0, 32'h40, 32'hA5A5A5A5, 4'b0101);
        access(1, 1'b0, 32'h40, 32'h0, 4'h0);
        checks += 2;
        if (rdata[1] !== 32'h11A533A5) begin errors++; $display("FAIL strobe_data: got %h expected 11a533a5", rdata[1]); end
        if (wcnt[1] !== 32'(exp_w[1])) begin errors++; $display("FAIL strobe_wcount: got %0d expected %0d", wcnt[1], exp_w[1]); end
    endtask

    task automatic test_mailbox();
        do_reset();
        access(0, 1'b0, 32'h1000, 32'h1, 4'hF);
        checks += 3;
        if (done[0] !== 1'b1) begin errors++; $display("FAIL mbox_done: got %b expected 1", done[0]); end
        if (pass[0] !== 1'b1) begin errors++; $display("FAIL mbox_pass: got %b expected 1", pass[0]); end
        if (err[0] !== 1'b1) begin errors++; $display("FAIL mbox_err: got %b expected 1 (0x1000 beyond RAM)", err[0]); end
        access(0, 1'b0, 32'h1000, 32'h0, 4'hF);
        checks += 2;
        if (done[0] !== 1'b1) begin errors++; $display("FAIL mbox_done2: got %b expected 1", done[0]); end
        if (pass[0] !== 1'b1) begin errors++; $display("FAIL mbox_pass_sticky: got %b expected 1", pass[0]); end
        do_reset();
        access(0, 1'b0, 32'h1000, 32'h2, 4'hF);
        checks += 2;
        if (done[0] !== 1'b1) begin errors++; $display("FAIL mbox_done3: got %b expected 1", done[0]); end
        if (pass[0] !== 1'b0) begin errors++; $display("FAIL mbox_fail_verdict: got %b expected 0", pass[0]); end
    endtask

    task automatic test_out_of_range();
        do_reset();
        access(1, 1'b0, 32'h0, 32'hCAFEF00D, 4'hF);
        checks++;
        if (err[1] !== 1'b0) begin errors++; $display("FAIL oor_err_clear: got %b expected 0", err[1]); end
        access(1, 1'b0, 32'h2000, 32'h0, 4'h0);
        checks++;
        if (err[1] !== 1'b1) begin errors++; $display("FAIL oor_err: got %b expected 1", err[1]); end
        access(1, 1'b0, 32'h2000, 32'hDEADBEEF, 4'hF);
        access(1, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++;
        if (rdata[1] !== 32'hCAFEF00D) begin errors++; $display("FAIL oor_write_dropped: got %h expected cafef00d", rdata[1]); end
    endtask

    task automatic test_reset_mid_write();
        access(1, 1'b0, 32'h8, 32'h13579BDF, 4'hF);
        instr = 1'b0; addr = 32'h8; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        valid[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        checks += 4;
        if (ready[1] !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", ready[1]); end
        if (rdata[1] !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h expected 0", rdata[1]); end
        if (err[1] !== 1'b0 || done[1] !== 1'b0 || pass[1] !== 1'b0) begin
            errors++; $display("FAIL midrst_flags: got err=%b done=%b pass=%b expected 0", err[1], done[1], pass[1]);
        end
        if (wcnt[1] !== 32'h0 || fcnt[1] !== 32'h0) begin
            errors++; $display("FAIL midrst_counts: got w=%0d f=%0d expected 0", wcnt[1], fcnt[1]);
        end
        valid[1] = 1'b0;
        #1;
        reset = 1'b0;
        exp_f[0] = 0; exp_f[1] = 0; exp_w[0] = 0; exp_w[1] = 0;
        @(posedge clk);
        #1;
        access(1, 1'b0, 32'h8, 32'h0, 4'h0);
        checks++;
        if (rdata[1] !== 32'h13579BDF) begin errors++; $display("FAIL midrst_ram: got %h expected 13579bdf", rdata[1]); end
    endtask

    task automatic test_drop_valid();
        bit seen;
        do_reset();
        instr = 1'b0; addr = 32'h8; wdata = 32'h0BADF00D; wstrb = 4'hF;
        valid[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        valid[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (ready[1] !== 1'b0) seen = 1'b1;
        end
        checks += 3;
        if (seen) begin errors++; $display("FAIL drop_ready: got mem_ready=1 after abort, expected 0"); end
        if (err[1] !== 1'b1) begin errors++; $display("FAIL drop_err: got %b expected 1", err[1]); end
        if (wcnt[1] !== 32'h0) begin errors++; $display("FAIL drop_wcount: got %0d expected 0", wcnt[1]); end
        access(1, 1'b0, 32'h8, 32'h0, 4'h0);
    endtask

    task automatic test_back_to_back();
        int unsigned start;
        logic [31:0] d;
        start = cyc;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            access(0, 1'b0, 32'h100 + 32'(4 * i), d, 4'hF);
        end
        for (int i = 0; i < 8; i++) begin
            access(0, 1'(i & 1), 32'h100 + 32'(4 * i), 32'h0, 4'h0);
        end
        checks += 3;
        if (cyc - start !== 32) begin errors++; $display("FAIL b2b_throughput: got %0d cycles, expected 32", cyc - start); end
        if (fcnt[0] !== 32'(exp_f[0])) begin errors++; $display("FAIL b2b_fcount: got %0d expected %0d", fcnt[0], exp_f[0]); end
        if (wcnt[0] !== 32'(exp_w[0])) begin errors++; $display("FAIL b2b_wcount: got %0d expected %0d", wcnt[0], exp_w[0]); end
    endtask

    initial begin
        reset = 1'b1;
        valid = 2'b00;
        instr = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        wstrb = 4'h0;
        test_reset();
        test_fetch();
        test_byte_strobe();
        test_mailbox();
        test_out_of_range();
        test_reset_mid_write();
        test_drop_valid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
